// File: rtl/fetch_predict.sv
// Instruction fetch stage: issues one icache request at a time, predecodes the
// returned instruction (JAL / BRANCH / JALR), predicts the next PC using the
// BHT for conditional branches, and queues {inst, pc, prediction} for decode.
module fetch_predict #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        ic_req,
    output logic [31:0] ic_addr,
    input  logic        ic_valid,
    input  logic [31:0] ic_inst,
    output logic [31:0] bht_index,
    input  logic        bht_taken,
    output logic        dq_valid,
    output logic [31:0] dq_inst,
    output logic [31:0] dq_pc,
    output logic [31:0] dq_pred_pc,
    output logic        dq_pred_taken,
    input  logic        dq_ready,
    input  logic        flush,
    input  logic [31:0] flush_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {IDLE, WAIT, DROP, STALL} state_t;

    state_t         state_q;
    logic [31:0]    pc_q;
    logic [31:0]    req_addr_q;
    logic [PW-1:0]  head_q, tail_q;
    logic [CW-1:0]  count_q;

    logic [31:0]    inst_mem  [DEPTH];
    logic [31:0]    pc_mem    [DEPTH];
    logic [31:0]    npc_mem   [DEPTH];
    logic [DEPTH-1:0] taken_mem;

    logic        not_full;
    logic        accept, push, pop, is_jalr;
    logic        taken;
    logic [31:0] npc, jimm, bimm;

    assign not_full  = (count_q < CW'(DEPTH));
    assign ic_addr   = (state_q == IDLE) ? pc_q : req_addr_q;
    assign bht_index = ic_addr;

    // Request line is a pure function of state; forced low while in reset.
    always_comb begin
        ic_req = 1'b0;
        case (state_q)
            IDLE:        ic_req = not_full;
            WAIT, DROP:  ic_req = 1'b1;
            default:     ic_req = 1'b0;
        endcase
        if (rst) ic_req = 1'b0;
    end

    assign accept = ic_req && ic_valid && (state_q == IDLE || state_q == WAIT);
    assign push   = accept && !flush;
    assign dq_valid = (count_q != '0);
    assign pop    = dq_valid && dq_ready;

    assign jimm = {{11{ic_inst[31]}}, ic_inst[31], ic_inst[19:12], ic_inst[20],
                   ic_inst[30:21], 1'b0};
    assign bimm = {{19{ic_inst[31]}}, ic_inst[31], ic_inst[7], ic_inst[30:25],
                   ic_inst[11:8], 1'b0};
    assign is_jalr = (ic_inst[6:0] == OP_JALR);

    // Static predecode plus BHT lookup produces the predicted next PC.
    always_comb begin
        taken = 1'b0;
        npc   = ic_addr + 32'd4;
        case (ic_inst[6:0])
            OP_JAL: begin
                taken = 1'b1;
                npc   = ic_addr + jimm;
            end
            OP_BRANCH: begin
                taken = bht_taken;
                if (bht_taken) npc = ic_addr + bimm;
            end
            default: ;
        endcase
    end

    // Queue payload storage; contents only matter while count covers them.
    always_ff @(posedge clk) begin
        if (!rst && rdy && push) begin
            inst_mem[tail_q]  <= ic_inst;
            pc_mem[tail_q]    <= ic_addr;
            npc_mem[tail_q]   <= npc;
            taken_mem[tail_q] <= taken;
        end
    end

    assign dq_inst       = inst_mem[head_q];
    assign dq_pc         = pc_mem[head_q];
    assign dq_pred_pc    = npc_mem[head_q];
    assign dq_pred_taken = taken_mem[head_q];

    // Fetch FSM, PC tracking and queue pointers; flush overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else if (rdy) begin
            if (flush) begin
                pc_q    <= flush_pc;
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
                case (state_q)
                    WAIT, DROP: state_q <= DROP;
                    IDLE: begin
                        // An unanswered request is still in flight: drop its reply.
                        if (ic_req && !ic_valid) begin
                            req_addr_q <= pc_q;
                            state_q    <= DROP;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end else begin
                if (push) tail_q <= tail_q + PW'(1);
                if (pop)  head_q <= head_q + PW'(1);
                case ({push, pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: ;
                endcase
                case (state_q)
                    IDLE, WAIT: begin
                        if (accept) begin
                            pc_q    <= npc;
                            state_q <= is_jalr ? STALL : IDLE;
                        end else if (state_q == IDLE && ic_req) begin
                            req_addr_q <= pc_q;
                            state_q    <= WAIT;
                        end
                    end
                    DROP: if (ic_valid) state_q <= IDLE;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_predict.sv
// Directed bench for fetch_predict with a small icache model of configurable
// latency and one programmable special instruction address.
module tb_fetch_predict;
    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        ic_req, ic_valid;
    logic [31:0] ic_addr, ic_inst, bht_index;
    logic        bht_taken;
    logic        dq_valid, dq_pred_taken, dq_ready;
    logic [31:0] dq_inst, dq_pc, dq_pred_pc;
    logic        flush;
    logic [31:0] flush_pc;

    localparam logic [31:0] ADDI = 32'h0000_0013;
    localparam logic [31:0] JAL  = 32'hFF9F_F06F;  // jal x0, -8
    localparam logic [31:0] BEQ  = 32'h0400_0063;  // beq x0, x0, +0x40
    localparam logic [31:0] JALR = 32'h0000_8067;  // jalr x0, 0(x1)

    int          n_cmp = 0;
    int          n_err = 0;
    int          lat;
    int          wcnt;
    logic [31:0] sp_addr, sp_inst;

    fetch_predict #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_valid(ic_valid), .ic_inst(ic_inst),
        .bht_index(bht_index), .bht_taken(bht_taken),
        .dq_valid(dq_valid), .dq_inst(dq_inst), .dq_pc(dq_pc),
        .dq_pred_pc(dq_pred_pc), .dq_pred_taken(dq_pred_taken), .dq_ready(dq_ready),
        .flush(flush), .flush_pc(flush_pc)
    );

    always #5 clk = ~clk;

    // icache model: answers after lat cycles of a held request
    assign ic_valid = ic_req && (wcnt >= lat);
    assign ic_inst  = (ic_addr == sp_addr) ? sp_inst : ADDI;
    always @(posedge clk) begin
        if (rst || !ic_req || ic_valid) wcnt <= 0;
        else if (rdy) wcnt <= wcnt + 1;
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; lat = 0; dq_ready = 1'b0; flush = 1'b0;
        flush_pc = 32'h0; bht_taken = 1'b0;
        sp_addr = 32'hFFFF_FFF0; sp_inst = ADDI;
        cyc(); cyc();
        chk("rst_ic_req", 32'(ic_req), 32'd0);
        chk("rst_dq_valid", 32'(dq_valid), 32'd0);
        chk("rst_ic_addr", ic_addr, 32'h0);
        chk("rst_bht_index", bht_index, 32'h0);

        // zero-latency stream of ADDI, decoder always ready
        rst = 1'b0; dq_ready = 1'b1; #1;
        chk("first_req", 32'(ic_req), 32'd1);
        cyc();
        chk("seq0_valid", 32'(dq_valid), 32'd1);
        chk("seq0_pc", dq_pc, 32'h0);
        chk("seq0_npc", dq_pred_pc, 32'h4);
        chk("seq0_taken", 32'(dq_pred_taken), 32'd0);
        cyc(); chk("seq1_pc", dq_pc, 32'h4);
        cyc(); chk("seq2_pc", dq_pc, 32'h8);
        cyc(); chk("seq3_pc", dq_pc, 32'hC);
        chk("seq3_valid", 32'(dq_valid), 32'd1);

        // JAL at 0x100, imm -8
        sp_addr = 32'h100; sp_inst = JAL; dq_ready = 1'b0;
        flush = 1'b1; flush_pc = 32'h100;
        cyc(); flush = 1'b0;
        chk("jal_flush_empty", 32'(dq_valid), 32'd0);
        chk("jal_addr", ic_addr, 32'h100);
        cyc();
        chk("jal_pc", dq_pc, 32'h100);
        chk("jal_inst", dq_inst, JAL);
        chk("jal_taken", 32'(dq_pred_taken), 32'd1);
        chk("jal_npc", dq_pred_pc, 32'hF8);
        chk("jal_next_addr", ic_addr, 32'hF8);

        // BEQ at 0x20, imm +0x40, predicted taken then not taken
        sp_addr = 32'h20; sp_inst = BEQ; bht_taken = 1'b1;
        flush = 1'b1; flush_pc = 32'h20;
        cyc(); flush = 1'b0;
        chk("beq_addr", ic_addr, 32'h20);
        cyc();
        chk("beqT_taken", 32'(dq_pred_taken), 32'd1);
        chk("beqT_npc", dq_pred_pc, 32'h60);
        chk("beqT_next_addr", ic_addr, 32'h60);
        bht_taken = 1'b0; flush = 1'b1; flush_pc = 32'h20;
        cyc(); flush = 1'b0;
        cyc();
        chk("beqN_pc", dq_pc, 32'h20);
        chk("beqN_taken", 32'(dq_pred_taken), 32'd0);
        chk("beqN_npc", dq_pred_pc, 32'h24);
        chk("beqN_next_addr", ic_addr, 32'h24);

        // queue fills with decoder stalled
        sp_addr = 32'hFFFF_FFF0;
        flush = 1'b1; flush_pc = 32'h200;
        cyc(); flush = 1'b0;
        cyc(); cyc(); cyc();
        chk("fill3_req", 32'(ic_req), 32'd1);
        cyc();
        chk("full_req", 32'(ic_req), 32'd0);
        chk("full_addr", ic_addr, 32'h210);
        chk("full_head", dq_pc, 32'h200);
        cyc();
        chk("full_hold_req", 32'(ic_req), 32'd0);
        chk("full_hold_head", dq_pc, 32'h200);
        dq_ready = 1'b1;
        cyc(); dq_ready = 1'b0;
        chk("pop_req", 32'(ic_req), 32'd1);
        chk("pop_head", dq_pc, 32'h204);
        cyc();
        chk("refill_req", 32'(ic_req), 32'd0);

        // flush while waiting on a latency-3 icache
        lat = 3;
        flush = 1'b1; flush_pc = 32'h300;
        cyc(); flush = 1'b0;
        chk("lat_addr", ic_addr, 32'h300);
        chk("lat_req", 32'(ic_req), 32'd1);
        cyc(); cyc();
        chk("wait_addr", ic_addr, 32'h300);
        flush = 1'b1; flush_pc = 32'h400;
        cyc(); flush = 1'b0;
        chk("drop_req", 32'(ic_req), 32'd1);
        chk("drop_addr", ic_addr, 32'h300);
        chk("drop_empty", 32'(dq_valid), 32'd0);
        cyc();
        chk("after_drop_empty", 32'(dq_valid), 32'd0);
        chk("after_drop_addr", ic_addr, 32'h400);
        cyc(); cyc(); cyc();
        chk("lat_not_yet", 32'(dq_valid), 32'd0);
        cyc();
        chk("lat_valid", 32'(dq_valid), 32'd1);
        chk("lat_pc", dq_pc, 32'h400);

        // JALR stalls fetch until a redirect
        lat = 0; sp_addr = 32'h40; sp_inst = JALR;
        flush = 1'b1; flush_pc = 32'h40;
        cyc(); flush = 1'b0;
        chk("jalr_addr", ic_addr, 32'h40);
        cyc();
        chk("stall_req", 32'(ic_req), 32'd0);
        chk("jalr_pc", dq_pc, 32'h40);
        chk("jalr_inst", dq_inst, JALR);
        chk("jalr_npc", dq_pred_pc, 32'h44);
        chk("jalr_taken", 32'(dq_pred_taken), 32'd0);
        rdy = 1'b0; dq_ready = 1'b1; flush = 1'b1; flush_pc = 32'h999;
        cyc();
        chk("frz_req", 32'(ic_req), 32'd0);
        chk("frz_valid", 32'(dq_valid), 32'd1);
        chk("frz_pc", dq_pc, 32'h40);
        rdy = 1'b1; dq_ready = 1'b0; flush = 1'b1; flush_pc = 32'h80;
        cyc(); flush = 1'b0;
        chk("redir_addr", ic_addr, 32'h80);
        chk("redir_bht", bht_index, 32'h80);
        chk("redir_req", 32'(ic_req), 32'd1);
        chk("redir_empty", 32'(dq_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
